// File: rtl/fram_pkg.sv
// Shared definitions for the fram_sp_be frame RAM: FSM state type, lane
// geometry helpers and the lane-parity width. Parity storage is selected
// with the FRAM_SP_PARITY_EN macro.
package fram_pkg;

  // Clear engine / normal operation.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } fram_state_t;

  // Data bits per byte lane.
  localparam int FRAM_LANE_W = 8;

`ifdef FRAM_SP_PARITY_EN
  // One even-parity bit stored next to every byte lane.
  localparam int FRAM_PAR_W = 1;
`else
  localparam int FRAM_PAR_W = 0;
`endif

  // Stored bits per lane (data plus optional parity).
  localparam int FRAM_STORE_LW = FRAM_LANE_W + FRAM_PAR_W;

  // Default geometry and the byte-lane count helper.
  localparam int FRAM_DEF_DW = 32;
  localparam int FRAM_NB     = FRAM_DEF_DW / 8;

  function automatic int fram_nb(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/fram_sp_core.sv
// Raw single-port block-RAM array: per-lane write enables and a registered
// synchronous read. No reset on the array; the clear engine upstream
// initialises it.
module fram_sp_core
  import fram_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int NB    = FRAM_NB,
  parameter int LW    = FRAM_STORE_LW
) (
  input  logic             clk,
  input  logic [AW-1:0]    i_addr,
  input  logic [NB-1:0]    i_lane_we,
  input  logic             i_re,
  input  logic [NB*LW-1:0] i_wdata,
  output logic [NB*LW-1:0] o_rdata
);

  (* syn_ramstyle = "block_ram" *) logic [NB*LW-1:0] r_mem [DEPTH];
  logic [NB*LW-1:0] r_rdata;

  // Per-lane write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (i_lane_we[i]) begin
        r_mem[i_addr][i*LW +: LW] <= i_wdata[i*LW +: LW];
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fram_sp_be.sv
// Single-port byte-enabled frame RAM with clear engine and registered read.
// Optional lane parity: define FRAM_SP_PARITY_EN.
//
// Handshake: there is no backpressure. ram_en qualifies one access per cycle
// and is accepted on every cycle init_busy is low (including the cycle it
// falls); while init_busy is high ram_en is ignored. Each accepted read
// produces exactly one rd_valid beat, 1 (OUT_REG=0) or 2 (OUT_REG=1) cycles
// later, with rd_data and par_err aligned to it. rd_data holds between beats.
module fram_sp_be
  import fram_pkg::*;
#(
  parameter int               MEM_SIZE = 1024,
  parameter int               AW       = 10,
  parameter int               FPGA_DW  = 32,
  parameter int               OUT_REG  = 0,
  parameter logic [FPGA_DW-1:0] INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        addr,
  input  logic [FPGA_DW-1:0]   wr_data,
  input  logic [FPGA_DW/8-1:0] byte_en,
  input  logic                 wr_en,
  input  logic                 ram_en,
  input  logic                 init_req,
  output logic [FPGA_DW-1:0]   rd_data,
  output logic                 rd_valid,
  output logic                 init_busy,
  output logic                 par_err,
  output fram_state_t          dbg_state
);

  localparam int NB = fram_nb(FPGA_DW);
  localparam int LW = FRAM_STORE_LW;
  localparam int SW = NB * LW;
  localparam logic [AW:0] LAST_X = (AW+1)'(MEM_SIZE - 1);
  localparam logic [AW:0] SIZE_X = (AW+1)'(MEM_SIZE);

  fram_state_t        r_state;
  logic [AW-1:0]      r_cnt;
  logic               w_run;
  logic               w_clr_last;
  logic               w_in_range;
  logic               w_acc;
  logic               w_rd;
  logic               w_wr;
  logic [FPGA_DW-1:0] w_src;
  logic [SW-1:0]      w_wst;
  logic [NB-1:0]      w_lane_we;
  logic [AW-1:0]      w_core_addr;
  logic [SW-1:0]      w_core_q;
  logic [FPGA_DW-1:0] w_core_data;
  logic               r_v1;
  logic               r_zero1;
  logic [FPGA_DW-1:0] w_d1;
  logic               w_pe1;

  assign w_run      = (r_state == RUN);
  assign w_clr_last = ({1'b0, r_cnt} == LAST_X);
  assign w_in_range = ({1'b0, addr} < SIZE_X);
  assign w_acc      = ram_en & w_run & ~rst;
  assign w_rd       = w_acc & ~wr_en;
  assign w_wr       = w_acc & wr_en & w_in_range;

  assign init_busy  = ~w_run;
  assign dbg_state  = r_state;

  // Clear engine FSM: sweep every word once, then serve accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else if (r_state == CLEAR) begin
      if (w_clr_last) begin
        r_state <= RUN;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (init_req) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end
  end

  // Build the stored word: clear value or user data, plus lane parity.
  always_comb begin
    w_src = w_run ? wr_data : INIT_VAL;
    w_wst = '0;
    for (int i = 0; i < NB; i++) begin
      w_wst[i*LW +: 8] = w_src[i*8 +: 8];
`ifdef FRAM_SP_PARITY_EN
      w_wst[i*LW + 8] = ^w_src[i*8 +: 8];
`endif
    end
  end

  // Lane enables: all lanes while clearing, byte_en for in-range user writes.
  always_comb begin
    w_lane_we = '0;
    if (!rst) begin
      if (!w_run) begin
        w_lane_we = '1;
      end else if (w_wr) begin
        w_lane_we = byte_en;
      end
    end
  end

  assign w_core_addr = w_run ? addr : r_cnt;

  fram_sp_core #(
    .DEPTH (MEM_SIZE),
    .AW    (AW),
    .NB    (NB),
    .LW    (LW)
  ) u_core (
    .clk       (clk),
    .i_addr    (w_core_addr),
    .i_lane_we (w_lane_we),
    .i_re      (w_rd & w_in_range),
    .i_wdata   (w_wst),
    .o_rdata   (w_core_q)
  );

  // Strip parity bits off the core output.
  always_comb begin
    w_core_data = '0;
    for (int i = 0; i < NB; i++) begin
      w_core_data[i*8 +: 8] = w_core_q[i*LW +: 8];
    end
  end

  // First read stage: beat strobe and out-of-range select, held between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_zero1 <= 1'b1;
    end else begin
      r_v1 <= w_rd;
      if (w_rd) begin
        r_zero1 <= ~w_in_range;
      end
    end
  end

  // Out-of-range reads and the post-reset value show as zero.
  assign w_d1 = r_zero1 ? '0 : w_core_data;

`ifdef FRAM_SP_PARITY_EN
  logic [NB-1:0] w_lane_mis;

  // Even parity per lane: a stored lane with odd weight is a mismatch.
  always_comb begin
    w_lane_mis = '0;
    for (int i = 0; i < NB; i++) begin
      w_lane_mis[i] = ^w_core_q[i*LW +: LW];
    end
  end

  assign w_pe1 = r_v1 & ~r_zero1 & (|w_lane_mis);
`else
  assign w_pe1 = 1'b0;
`endif

  if (OUT_REG != 0) begin : g_oreg
    logic [FPGA_DW-1:0] r_d2;
    logic               r_v2;
    logic               r_pe2;

    // Second output stage: capture on beats only so rd_data holds when idle.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_d2  <= '0;
        r_v2  <= 1'b0;
        r_pe2 <= 1'b0;
      end else begin
        r_v2  <= r_v1;
        r_pe2 <= w_pe1;
        if (r_v1) begin
          r_d2 <= w_d1;
        end
      end
    end

    assign rd_data  = r_d2;
    assign rd_valid = r_v2;
    assign par_err  = r_pe2;
  end else begin : g_noreg
    assign rd_data  = w_d1;
    assign rd_valid = r_v1;
    assign par_err  = w_pe1;
  end

endmodule

// File: tb/tb_fram_sp_be.sv
// Bench for fram_sp_be: two instances share stimulus (16 words / OUT_REG=0
// and 12 words / OUT_REG=1) and are compared every cycle against a word-level
// memory model with an expected-read queue per instance.
module tb_fram_sp_be;
  import fram_pkg::*;

  localparam logic [31:0] IV = 32'hA5A5A5A5;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        ram_en;
  logic        wr_en;
  logic        init_req;
  logic [3:0]  addr;
  logic [3:0]  byte_en;
  logic [31:0] wr_data;

  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1;
  logic        init_busy0, init_busy1;
  logic        par_err0, par_err1;
  fram_state_t dbg0, dbg1;

  always #5 clk = ~clk;

  fram_sp_be #(.MEM_SIZE(16), .AW(4), .FPGA_DW(32), .OUT_REG(0), .INIT_VAL(IV)) u_d0 (
    .clk(clk), .rst(rst), .addr(addr), .wr_data(wr_data), .byte_en(byte_en),
    .wr_en(wr_en), .ram_en(ram_en), .init_req(init_req), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .init_busy(init_busy0), .par_err(par_err0), .dbg_state(dbg0)
  );

  fram_sp_be #(.MEM_SIZE(12), .AW(4), .FPGA_DW(32), .OUT_REG(1), .INIT_VAL(IV)) u_d1 (
    .clk(clk), .rst(rst), .addr(addr), .wr_data(wr_data), .byte_en(byte_en),
    .wr_en(wr_en), .ram_en(ram_en), .init_req(init_req), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .init_busy(init_busy1), .par_err(par_err1), .dbg_state(dbg1)
  );

  // ---------------- reference model / scoreboard ----------------
  int          msize [2] = '{16, 12};
  logic [31:0] mm [2][16];
  bit          corrupt [2][16];
  int          clr_left [2];
  logic [33:0] exp_q0[$];   // {par_err, valid, data}, latency 1
  logic [33:0] exp_q1[$];   // latency 2: one entry always in flight
  logic [31:0] e_rd [2];
  bit          e_v [2];
  bit          e_pe [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the current inputs.
  task automatic model_step();
    logic [33:0] ent;
    logic [33:0] pop;
    int a;
    a = int'(addr);
    for (int k = 0; k < 2; k++) begin
      ent = '0;
      pop = '0;
      if (rst) begin
        clr_left[k] = msize[k];
        e_rd[k] = '0;
        e_v[k]  = 1'b0;
        e_pe[k] = 1'b0;
        if (k == 0) begin
          exp_q0.delete();
        end else begin
          exp_q1.delete();
          exp_q1.push_back('0);
        end
      end else begin
        if (clr_left[k] > 0) begin
          mm[k][msize[k] - clr_left[k]] = IV;
          corrupt[k][msize[k] - clr_left[k]] = 1'b0;
          clr_left[k]--;
        end else begin
          if (init_req) clr_left[k] = msize[k];
          if (ram_en && wr_en && a < msize[k]) begin
            for (int b = 0; b < 4; b++) begin
              if (byte_en[b]) begin
                mm[k][a][8*b +: 8] = wr_data[8*b +: 8];
                if (b == 0) corrupt[k][a] = 1'b0;
              end
            end
          end
          if (ram_en && !wr_en) begin
            ent[32] = 1'b1;
            if (a < msize[k]) begin
              ent[31:0] = mm[k][a];
              ent[33]   = corrupt[k][a];
            end
          end
        end
        if (k == 0) begin
          exp_q0.push_back(ent);
          pop = exp_q0.pop_front();
        end else begin
          exp_q1.push_back(ent);
          pop = exp_q1.pop_front();
        end
        e_v[k]  = pop[32];
        e_pe[k] = pop[33];
        if (pop[32]) e_rd[k] = pop[31:0];
      end
    end
  endtask

  // One clock: update model, let the edge pass, compare all outputs.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("d0_valid", 32'(rd_valid0), 32'(e_v[0]));
    chk("d0_data",  rd_data0, e_rd[0]);
    chk("d0_busy",  32'(init_busy0), 32'(clr_left[0] > 0));
    chk("d0_perr",  32'(par_err0), 32'(e_pe[0]));
    chk("d1_valid", 32'(rd_valid1), 32'(e_v[1]));
    chk("d1_data",  rd_data1, e_rd[1]);
    chk("d1_busy",  32'(init_busy1), 32'(clr_left[1] > 0));
    chk("d1_perr",  32'(par_err1), 32'(e_pe[1]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drv(input logic en, input logic we, input logic [3:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    ram_en   = en;
    wr_en    = we;
    addr     = a;
    wr_data  = d;
    byte_en  = be;
    init_req = 1'b0;
  endtask

  task automatic drv_idle();
    drv(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
  endtask

  task automatic drv_rand_read();
    drv(1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)), 32'd0, 4'd0);
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      drv(1'b1, 1'b0, 4'(a), 32'd0, 4'd0);
      step();
    end
    drv_idle();
    step();
    step();
  endtask

  // Count busy cycles of the 16-word instance, starting on the cycle it is busy.
  task automatic count_busy(output int nb, input int ireq_at);
    nb = 0;
    while (init_busy0 && nb < 100) begin
      drv_rand_read();
      init_req = (nb == ireq_at);
      nb++;
      step();
    end
  endtask

  // ---------------- main sequence ----------------
  int nb;
  int r;

  initial begin
    rst = 1'b1;
    drv_idle();
    step();
    step();
    chk("rst_rd_data1", rd_data1, 32'd0);
    rst = 1'b0;

    // Power-up clear with reads attempted throughout.
    count_busy(nb, -1);
    chk("busy_len_reset", 32'(nb), 32'd16);
    read_all();

    // Byte lane merge.
    drv(1'b1, 1'b1, 4'd3, 32'h11223344, 4'b1111); step();
    drv(1'b1, 1'b1, 4'd3, 32'hFFFFFFFF, 4'b0101); step();
    drv(1'b1, 1'b0, 4'd3, 32'd0, 4'd0);           step();
    chk("lane_merge0", rd_data0, 32'h11FF33FF);
    drv_idle(); step();
    chk("lane_merge1", rd_data1, 32'h11FF33FF);
    drv(1'b1, 1'b1, 4'd3, 32'h0, 4'b0000); step();   // byte_en=0 no-op
    drv(1'b1, 1'b0, 4'd3, 32'd0, 4'd0);    step();
    chk("be_zero_noop", rd_data0, 32'h11FF33FF);

    // Back-to-back reads 1,2,3 then idle (hold).
    for (int a = 1; a <= 3; a++) begin
      drv(1'b1, 1'b0, 4'(a), 32'd0, 4'd0);
      step();
    end
    drv_idle();
    repeat (4) step();

    // Out-of-range write dropped, read returns zero with valid.
    drv(1'b1, 1'b1, 4'd13, 32'hDEADBEEF, 4'hF); step();
    drv(1'b1, 1'b0, 4'd13, 32'd0, 4'd0);        step();
    drv_idle(); step();
    chk("oor_valid1", 32'(rd_valid1), 32'd1);
    chk("oor_data1", rd_data1, 32'd0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      drv(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          $urandom, 4'($urandom_range(0, 15)));
      step();
    end

    // init_req clear with a second request mid-clear.
    drv_idle();
    init_req = 1'b1;
    step();
    count_busy(nb, 5);
    chk("busy_len_ireq", 32'(nb), 32'd16);
    read_all();

    // Reset at clear counter 7 restarts the clear.
    drv_idle();
    init_req = 1'b1;
    step();
    drv_idle();
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(nb, -1);
    chk("busy_len_rst7", 32'(nb), 32'd16);

    // Reset while a read is in flight drops it.
    drv(1'b1, 1'b0, 4'd5, 32'd0, 4'd0); step();
    drv_idle();
    rst = 1'b1;
    step();
    chk("rst_drop_valid1", 32'(rd_valid1), 32'd0);
    rst = 1'b0;
    count_busy(nb, -1);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 400; i++) begin
      drv(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          $urandom, 4'($urandom_range(0, 15)));
      r = int'($urandom_range(0, 199));
      if (r < 3) begin
        ram_en   = 1'b0;
        init_req = 1'b1;
      end
      rst = (r == 199);
      step();
      rst = 1'b0;
    end
    drv_idle();
    count_busy(nb, -1);

`ifdef FRAM_SP_PARITY_EN
    // Corrupt one stored data bit and expect a parity error on its read.
    drv(1'b1, 1'b1, 4'd2, 32'h0F0F1234, 4'hF); step();
    drv_idle(); step();
    u_d0.u_core.r_mem[2][0] = ~u_d0.u_core.r_mem[2][0];
    u_d1.u_core.r_mem[2][0] = ~u_d1.u_core.r_mem[2][0];
    for (int k = 0; k < 2; k++) begin
      mm[k][2][0] = ~mm[k][2][0];
      corrupt[k][2] = 1'b1;
    end
    drv(1'b1, 1'b0, 4'd2, 32'd0, 4'd0); step();
    chk("par_err_flip0", 32'(par_err0), 32'd1);
    drv(1'b1, 1'b0, 4'd4, 32'd0, 4'd0); step();
    chk("par_err_flip1", 32'(par_err1), 32'd1);
    chk("par_err_clean0", 32'(par_err0), 32'd0);
    drv_idle(); step();
    chk("par_err_clean1", 32'(par_err1), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Run-time bound.
  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

endmodule
